// File: rtl/cmd_window_if.sv
// cmd_window_if: command/window/status bundle between the fast-domain driver (master) and cmd_window_gen (slave)
interface cmd_window_if #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
);
  logic             command_en_sync;
  logic [WIN_W-1:0] win_len;
  logic             clr_status;
  logic             cmd_start;
  logic             win_active;
  logic             busy;
  logic [CNT_W-1:0] cmd_count;
  logic             overrun;
  modport master (
    output command_en_sync, win_len, clr_status,
    input  cmd_start, win_active, busy, cmd_count, overrun
  );
  modport slave (
    input  command_en_sync, win_len, clr_status,
    output cmd_start, win_active, busy, cmd_count, overrun
  );
endinterface

// File: rtl/cmd_window_gen.sv
// cmd_window_gen: accepts rising edges of command_en_sync on clk_fast (async reset rstn_fast), strobes cmd_start, opens a win_len window plus holdoff, counts commands and flags overruns over the bus slave port
module cmd_window_gen #(
  parameter int WIN_W   = 16,
  parameter int CNT_W   = 16,
  parameter int HOLDOFF = 4
) (
  input logic         clk_fast,
  input logic         rstn_fast,
  cmd_window_if.slave bus
);
  localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
  localparam int CW = WIN_W > HW ? WIN_W : HW;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
  localparam logic [1:0] IDLE = 2'd0, WINDOW = 2'd1, HOLD = 2'd2;
  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             prev, rise, accept, drop;
  always_comb begin
    rise      = bus.command_en_sync & ~prev;
    accept    = rise & (state == IDLE);
    drop      = rise & (state != IDLE);
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) begin
        state_nxt = |bus.win_len ? WINDOW : (HOLDOFF > 0 ? HOLD : IDLE);
        cnt_nxt   = |bus.win_len ? CW'(bus.win_len - 1'b1) : HOLD_LD;
      end
      WINDOW: begin
        state_nxt = |cnt ? WINDOW : (HOLDOFF > 0 ? HOLD : IDLE);
        cnt_nxt   = |cnt ? cnt - 1'b1 : HOLD_LD;
      end
      HOLD: begin
        state_nxt = |cnt ? HOLD : IDLE;
        cnt_nxt   = |cnt ? cnt - 1'b1 : cnt;
      end
      default: state_nxt = IDLE;
    endcase
    count_nxt = bus.clr_status ? CNT_W'(accept) : bus.cmd_count + CNT_W'(accept & ~&bus.cmd_count);
  end
  always_ff @(posedge clk_fast or negedge rstn_fast) begin
    if (!rstn_fast) begin
      state          <= IDLE;
      cnt            <= '0;
      prev           <= 1'b1;
      bus.cmd_start  <= 1'b0;
      bus.win_active <= 1'b0;
      bus.busy       <= 1'b0;
      bus.cmd_count  <= '0;
      bus.overrun    <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      prev           <= bus.command_en_sync;
      bus.cmd_start  <= accept;
      bus.win_active <= state_nxt == WINDOW;
      bus.busy       <= state_nxt != IDLE;
      bus.cmd_count  <= count_nxt;
      bus.overrun    <= ~bus.clr_status & (bus.overrun | drop);
    end
  end
endmodule

// File: tb/tb_cmd_window_gen.sv
// tb_cmd_window_gen: randomized and directed checks of cmd_window_gen against an interval-based reference model
module tb_cmd_window_gen;
  localparam int HOLDOFF = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  cmd_window_if #(.WIN_W(16), .CNT_W(16)) bus ();
  cmd_window_if #(.WIN_W(16), .CNT_W(2))  bus2 ();
  assign bus2.command_en_sync = bus.command_en_sync;
  assign bus2.win_len         = bus.win_len;
  assign bus2.clr_status      = bus.clr_status;
  cmd_window_gen #(.WIN_W(16), .CNT_W(16), .HOLDOFF(HOLDOFF)) dut (
    .clk_fast(clk), .rstn_fast(rstn), .bus(bus));
  cmd_window_gen #(.WIN_W(16), .CNT_W(2), .HOLDOFF(HOLDOFF)) dut2 (
    .clk_fast(clk), .rstn_fast(rstn), .bus(bus2));
  int n_chk = 0;
  int n_fail = 0;
  int e = 0;
  int acc_e = -100;
  int win_last = -100;
  int busy_last = -100;
  int m_cnt = 0;
  int m_cnt2 = 0;
  bit m_prev = 1'b1;
  bit m_ovr = 1'b0;
  logic [19:0] exp_v = '0;
  logic [2:0]  exp2 = '0;
  logic [19:0] obs;
  logic [2:0]  obs2;
  assign obs  = {bus.cmd_start, bus.win_active, bus.busy, bus.overrun, bus.cmd_count};
  assign obs2 = {bus2.cmd_start, bus2.cmd_count};

  task automatic model_reset();
    m_prev = 1'b1;
    win_last = -100;
    busy_last = -100;
    m_cnt = 0;
    m_cnt2 = 0;
    m_ovr = 1'b0;
    exp_v = '0;
    exp2 = '0;
  endtask

  task automatic model_edge();
    bit rise, idle, acc, drop;
    e++;
    rise = bus.command_en_sync && !m_prev;
    m_prev = bus.command_en_sync;
    idle = (e - 1) > busy_last;
    acc = rise && idle;
    drop = rise && !idle;
    if (acc) begin
      acc_e = e;
      win_last = e + int'(bus.win_len) - 1;
      busy_last = win_last + HOLDOFF;
    end
    if (bus.clr_status) begin
      m_cnt = int'(acc);
      m_cnt2 = int'(acc);
      m_ovr = 1'b0;
    end else begin
      if (acc && m_cnt < 65535) m_cnt++;
      if (acc && m_cnt2 < 3) m_cnt2++;
      m_ovr = m_ovr | drop;
    end
    exp_v = {acc, (e >= acc_e && e <= win_last), (e >= acc_e && e <= busy_last), m_ovr, 16'(m_cnt)};
    exp2 = {acc, 2'(m_cnt2)};
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic go_idle();
    bus.command_en_sync = 1'b0;
    bus.clr_status = 1'b0;
    repeat (25) cycle();
  endtask

  task automatic test_reset();
    int ns, nw, nb;
    bus.command_en_sync = 1'b1;
    bus.win_len = 16'd8;
    bus.clr_status = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (obs !== 20'd0 || obs2 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h/%h want 0/0", obs, obs2);
    end
    rstn = 1'b1;
    model_reset();
    repeat (5) begin
      cycle();
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_level_high cyc %0d: got %h want %h", e, obs, exp_v);
      end
    end
    bus.command_en_sync = 1'b0;
    cycle();
    bus.command_en_sync = 1'b1;
    ns = 0; nw = 0; nb = 0;
    repeat (16) begin
      cycle();
      ns += int'(bus.cmd_start);
      nw += int'(bus.win_active);
      nb += int'(bus.busy);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_first_cmd cyc %0d: got %h want %h", e, obs, exp_v);
      end
    end
    n_chk++;
    if (ns != 1 || nw != 8 || nb != 12 || bus.cmd_count !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_first_totals: got start=%0d win=%0d busy=%0d cnt=%0d want 1/8/12/1", ns, nw, nb, bus.cmd_count);
    end
  endtask

  task automatic test_basic_window();
    int ns, nw, nb;
    go_idle();
    bus.win_len = 16'd3;
    bus.command_en_sync = 1'b1;
    ns = 0; nw = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      ns += int'(bus.cmd_start);
      nw += int'(bus.win_active);
      nb += int'(bus.busy);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL basic_window step %0d: got %h want %h", i, obs, exp_v);
      end
      bus.win_len = 16'd9;
      bus.command_en_sync = 1'b0;
    end
    n_chk++;
    if (ns != 1 || nw != 3 || nb != 7 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_window_totals: got start=%0d win=%0d busy=%0d busy_end=%b want 1/3/7/0", ns, nw, nb, bus.busy);
    end
  endtask

  task automatic test_overrun();
    int ns, nw;
    go_idle();
    bus.clr_status = 1'b1;
    cycle();
    bus.clr_status = 1'b0;
    bus.win_len = 16'd10;
    bus.command_en_sync = 1'b1;
    ns = 0; nw = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      ns += int'(bus.cmd_start);
      nw += int'(bus.win_active);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL overrun step %0d: got %h want %h", i, obs, exp_v);
      end
      bus.command_en_sync = (i == 1);
    end
    n_chk++;
    if (ns != 1 || nw != 10 || bus.overrun !== 1'b1 || bus.cmd_count !== 16'd1) begin
      n_fail++;
      $display("FAIL overrun_totals: got start=%0d win=%0d ovr=%b cnt=%0d want 1/10/1/1", ns, nw, bus.overrun, bus.cmd_count);
    end
    bus.clr_status = 1'b1;
    cycle();
    bus.clr_status = 1'b0;
    n_chk++;
    if (bus.cmd_count !== 16'd0 || bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got cnt=%0d ovr=%b want 0/0", bus.cmd_count, bus.overrun);
    end
  endtask

  task automatic test_zero_len();
    int ns, nw, nb;
    go_idle();
    bus.clr_status = 1'b1;
    cycle();
    bus.clr_status = 1'b0;
    bus.win_len = 16'd0;
    bus.command_en_sync = 1'b1;
    ns = 0; nw = 0; nb = 0;
    repeat (8) begin
      cycle();
      ns += int'(bus.cmd_start);
      nw += int'(bus.win_active);
      nb += int'(bus.busy);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL zero_len cyc %0d: got %h want %h", e, obs, exp_v);
      end
      bus.command_en_sync = 1'b0;
    end
    n_chk++;
    if (ns != 1 || nw != 0 || nb != 4 || bus.cmd_count !== 16'd1) begin
      n_fail++;
      $display("FAIL zero_len_totals: got start=%0d win=%0d busy=%0d cnt=%0d want 1/0/4/1", ns, nw, nb, bus.cmd_count);
    end
    bus.command_en_sync = 1'b1;
    bus.clr_status = 1'b1;
    cycle();
    bus.clr_status = 1'b0;
    bus.command_en_sync = 1'b0;
    n_chk++;
    if (bus.cmd_count !== 16'd1 || bus.cmd_start !== 1'b1 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL clear_with_accept: got cnt=%0d start=%b want 1/1", bus.cmd_count, bus.cmd_start);
    end
  endtask

  task automatic test_saturation();
    int want[5] = '{1, 2, 3, 3, 3};
    int ns;
    go_idle();
    bus.clr_status = 1'b1;
    cycle();
    bus.clr_status = 1'b0;
    bus.win_len = 16'd2;
    ns = 0;
    for (int i = 0; i < 5; i++) begin
      bus.command_en_sync = 1'b1;
      cycle();
      ns += int'(bus2.cmd_start);
      n_chk++;
      if (bus2.cmd_count !== 2'(want[i]) || obs2 !== exp2) begin
        n_fail++;
        $display("FAIL saturation cmd %0d: got cnt=%0d want %0d", i, bus2.cmd_count, want[i]);
      end
      bus.command_en_sync = 1'b0;
      repeat (8) cycle();
    end
    n_chk++;
    if (ns != 5) begin
      n_fail++;
      $display("FAIL saturation_strobes: got %0d want 5", ns);
    end
  endtask

  task automatic test_reset_mid();
    int ns;
    go_idle();
    bus.win_len = 16'd20;
    bus.command_en_sync = 1'b1;
    repeat (5) begin
      cycle();
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_window cyc %0d: got %h want %h", e, obs, exp_v);
      end
    end
    rstn = 1'b0;
    #1;
    n_chk++;
    if (obs !== 20'd0 || obs2 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h/%h want 0/0", obs, obs2);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    ns = 0;
    repeat (5) begin
      cycle();
      ns += int'(bus.cmd_start);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_held cyc %0d: got %h want %h", e, obs, exp_v);
      end
    end
    n_chk++;
    if (ns != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_strobe: got %0d strobes want 0", ns);
    end
    bus.command_en_sync = 1'b0;
    cycle();
    bus.command_en_sync = 1'b1;
    cycle();
    n_chk++;
    if (bus.cmd_start !== 1'b1 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_fresh_edge: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_random();
    go_idle();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) bus.command_en_sync = ~bus.command_en_sync;
      bus.win_len = 16'($urandom_range(0, 12));
      bus.clr_status = ($urandom_range(0, 15) == 0);
      cycle();
      n_chk++;
      if (obs !== exp_v || obs2 !== exp2) begin
        n_fail++;
        $display("FAIL random step %0d: got %h/%h want %h/%h", i, obs, obs2, exp_v, exp2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_overrun();
    test_zero_len();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
